// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: default widths and the control state type.
package mult_pkg;

  localparam int unsigned WIDTH_M = 16;
  localparam int unsigned WIDTH_P = 2 * WIDTH_M;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ADD,
    SHIFT,
    DONE
  } mult_state_t;

endpackage

// File: rtl/iteration_counter.sv
// Iteration counter for the multiplier sequencer: synchronous clear, saturating increment,
// and a flag marking the final iteration.
module iteration_counter
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH_M = mult_pkg::WIDTH_M,
  parameter int unsigned CNT_W   = $clog2(WIDTH_M + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_d;

  // Next count: clear wins over increment; increment stops at WIDTH_M.
  always_comb begin
    w_count_d = r_count;
    if (clear) begin
      w_count_d = '0;
    end else if (inc && (r_count != CNT_W'(WIDTH_M))) begin
      w_count_d = r_count + CNT_W'(1);
    end
  end

  // Count register with asynchronous reset to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_d;
    end
  end

  assign count = r_count;
  assign last  = (r_count == CNT_W'(WIDTH_M - 1));

endmodule

// File: rtl/mult_sequencer.sv
// Control FSM for the shift-add sequential multiplier: LOAD, then WIDTH_M ADD/SHIFT pairs,
// then a one-cycle DONE pulse. Abort returns to IDLE from any state without touching iter.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH_M = mult_pkg::WIDTH_M,
  parameter int unsigned CNT_W   = $clog2(WIDTH_M + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             q0,
  output logic             load_signal,
  output logic             mux_signal,
  output logic             add_signal,
  output logic             shift_signal,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter
);

  mult_state_t r_state;
  mult_state_t w_state_d;
  logic        w_cnt_clear;
  logic        w_cnt_inc;
  logic        w_cnt_last;

  // Abort suppresses counter updates so iter holds its value on cancel.
  assign w_cnt_clear = (r_state == LOAD) && !abort;
  assign w_cnt_inc   = (r_state == SHIFT) && !abort;

  iteration_counter #(
    .WIDTH_M (WIDTH_M),
    .CNT_W   (CNT_W)
  ) u_iteration_counter (
    .clk   (clk),
    .reset (reset),
    .clear (w_cnt_clear),
    .inc   (w_cnt_inc),
    .count (iter),
    .last  (w_cnt_last)
  );

  // Next-state logic; abort overrides every transition.
  always_comb begin
    w_state_d = r_state;
    if (abort) begin
      w_state_d = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    w_state_d = start ? LOAD : IDLE;
        LOAD:    w_state_d = ADD;
        ADD:     w_state_d = SHIFT;
        SHIFT:   w_state_d = w_cnt_last ? DONE : ADD;
        DONE:    w_state_d = IDLE;
        default: w_state_d = IDLE;
      endcase
    end
  end

  // State register with asynchronous reset to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Output decode; mux_signal is the only Mealy output (follows q0 in ADD).
  always_comb begin
    load_signal  = 1'b0;
    mux_signal   = 1'b0;
    add_signal   = 1'b0;
    shift_signal = 1'b0;
    done         = 1'b0;
    busy         = (r_state != IDLE);
    unique case (r_state)
      IDLE:  ;
      LOAD:  load_signal = 1'b1;
      ADD: begin
        add_signal = 1'b1;
        mux_signal = q0;
      end
      SHIFT: shift_signal = 1'b1;
      DONE:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer: stimulus pushes the cycle-stamped expected control
// sequence of each multiply; a negedge monitor pops and compares whenever the DUT is active.
module tb_mult_sequencer;

  localparam int W     = 16;
  localparam int CNT_W = $clog2(W + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic             q0;
  logic             load_signal;
  logic             mux_signal;
  logic             add_signal;
  logic             shift_signal;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] iter;

  typedef struct {
    logic       load;
    logic       add;
    logic       shift;
    logic       mux;
    logic       done;
    logic       chk_iter;
    int         iter;
    int         cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          add_cnt     = 0;
  int          shift_cnt   = 0;
  int          done_cnt    = 0;
  logic [W-1:0] mval_cur;
  logic [W-1:0] sr;

  mult_sequencer #(
    .WIDTH_M (W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .q0           (q0),
    .load_signal  (load_signal),
    .mux_signal   (mux_signal),
    .add_signal   (add_signal),
    .shift_signal (shift_signal),
    .busy         (busy),
    .done         (done),
    .iter         (iter)
  );

  always #5 clk = ~clk;

  // Cycle index: the cycle that starts at an edge carries the incremented value.
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stand-in: multiplier register that loads on LOAD and shifts right on SHIFT.
  always @(posedge clk or posedge reset) begin
    if (reset) sr <= '0;
    else if (load_signal) sr <= mval_cur;
    else if (shift_signal) sr <= {1'b0, sr[W-1:1]};
  end
  assign q0 = sr[0];

  // Monitor: invariants every cycle, scoreboard pop whenever the DUT shows activity.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      vectors++;
      if (!$onehot0({load_signal, add_signal, shift_signal})) begin
        miscompares++;
        $display("FAIL onehot cyc=%0d got l/a/s=%b%b%b want at most one high", cyc,
                 load_signal, add_signal, shift_signal);
      end
      vectors++;
      if (mux_signal && !add_signal) begin
        miscompares++;
        $display("FAIL mux_outside_add cyc=%0d got mux=1 want 0", cyc);
      end
      if (add_signal) add_cnt++;
      if (shift_signal) shift_cnt++;
      if (done) done_cnt++;
      if (busy || done || load_signal || add_signal || shift_signal || mux_signal) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_activity cyc=%0d got busy=%b done=%b l/a/s/m=%b%b%b%b want idle",
                   cyc, busy, done, load_signal, add_signal, shift_signal, mux_signal);
        end else begin
          e = exp_q.pop_front();
          if (cyc != e.cyc ||
              {load_signal, add_signal, shift_signal, mux_signal, done, busy} !=
              {e.load, e.add, e.shift, e.mux, e.done, 1'b1} ||
              (e.chk_iter && int'(iter) != e.iter)) begin
            miscompares++;
            $display("FAIL sequence cyc=%0d got l/a/s/m/d/b=%b%b%b%b%b%b iter=%0d want cyc=%0d l/a/s/m/d/b=%b%b%b%b%b1 iter=%0d",
                     cyc, load_signal, add_signal, shift_signal, mux_signal, done, busy, iter,
                     e.cyc, e.load, e.add, e.shift, e.mux, e.done, e.iter);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Expected control sequence of one multiply whose start is accepted at the end of cycle base.
  task automatic push_txn(input logic [W-1:0] m, input int abort_iter, input int base);
    exp_t r;
    r = '{load: 1'b1, add: 1'b0, shift: 1'b0, mux: 1'b0, done: 1'b0, chk_iter: 1'b0,
          iter: 0, cyc: base + 1};
    exp_q.push_back(r);
    for (int i = 0; i < W; i++) begin
      r = '{load: 1'b0, add: 1'b1, shift: 1'b0, mux: m[i], done: 1'b0, chk_iter: 1'b1,
            iter: i, cyc: base + 2 + 2 * i};
      exp_q.push_back(r);
      if (abort_iter == i) return;
      r = '{load: 1'b0, add: 1'b0, shift: 1'b1, mux: 1'b0, done: 1'b0, chk_iter: 1'b1,
            iter: i, cyc: base + 3 + 2 * i};
      exp_q.push_back(r);
    end
    r = '{load: 1'b0, add: 1'b0, shift: 1'b0, mux: 1'b0, done: 1'b1, chk_iter: 1'b1,
          iter: W, cyc: base + 2 + 2 * W};
    exp_q.push_back(r);
  endtask

  // Called at posedge+1; returns at posedge+1 once the scoreboard is empty and the DUT idle.
  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    if (n >= 200) begin
      miscompares++;
      $display("FAIL %s_timeout got pending=%0d busy=%b want drained", name, exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  // Called at posedge+1; pulses start and optionally aborts in the ADD of iteration abort_iter.
  task automatic start_mult(input logic [W-1:0] m, input int abort_iter);
    mval_cur = m;
    push_txn(m, abort_iter, cyc);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (abort_iter >= 0) begin
      repeat (2 * abort_iter + 1) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_iter", int'(iter), abort_iter);
    end
  endtask

  initial begin
    logic [W-1:0] m;
    int           ab;
    int           base;

    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    mval_cur = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", int'({load_signal, mux_signal, add_signal, shift_signal, busy, done}), 0);
    check("reset_iter", int'(iter), 0);
    reset = 1'b0;

    // Multiplier 0x0005: mux high only in ADD of iterations 0 and 2, done at k+34.
    start_mult(16'h0005, -1);
    wait_drain("m0005");
    check("m0005_iter", int'(iter), W);

    // Multiplier 0xFFFF: every ADD selects the multiplicand.
    add_cnt   = 0;
    shift_cnt = 0;
    start_mult(16'hFFFF, -1);
    wait_drain("mffff");
    check("mffff_adds", add_cnt, W);
    check("mffff_shifts", shift_cnt, W);

    // Start held high: one done at k+34, then restart with LOAD at k+36.
    m        = W'($urandom);
    mval_cur = m;
    base     = cyc;
    done_cnt = 0;
    push_txn(m, -1, base);
    push_txn(m, -1, base + 2 * W + 3);
    start = 1'b1;
    repeat (2 * W + 8) @(posedge clk);
    #1 start = 1'b0;
    wait_drain("hold");
    check("hold_dones", done_cnt, 2);

    // Abort in ADD of iteration 5, then a normal multiply.
    done_cnt = 0;
    start_mult(W'($urandom), 5);
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    check("abort_iter_hold", int'(iter), 5);
    start_mult(W'($urandom), -1);
    wait_drain("after_abort");
    check("after_abort_iter", int'(iter), W);

    // Abort and start together in IDLE stays idle.
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    check("abort_start_idle", int'(busy), 0);

    // Randomised multiplies with occasional aborts.
    for (int t = 0; t < 6; t++) begin
      m  = W'($urandom);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      start_mult(m, ab);
      wait_drain("random");
      check("random_iter", int'(iter), (ab >= 0) ? ab : W);
    end

    // Reset in the middle of ADD: outputs and iter clear without a clock edge.
    start_mult(W'($urandom), -1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_outputs",
          int'({load_signal, mux_signal, add_signal, shift_signal, busy, done}), 0);
    check("midreset_iter", int'(iter), 0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    done_cnt = 0;
    repeat (10) @(posedge clk);
    #1;
    check("post_reset_busy", int'(busy), 0);
    check("post_reset_dones", done_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
